// File: rtl/seg7_pkg.sv
// Shared constants and state encoding for the two-digit 7-segment scan driver.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_ZERO = 7'b0000001;
  localparam logic [1:0] AN_OFF   = 2'b11;

  typedef enum logic [2:0] {
    S_OFF,
    S_UNITS,
    S_BLANK_U,
    S_TENS,
    S_BLANK_T
  } scan_state_t;

endpackage

// File: rtl/scan_phase_timer.sv
// Loadable down-counter that measures how long the scan FSM stays in a phase.
// done is high while the count is zero; the counter parks at zero until reloaded.
module scan_phase_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  // Reload on request, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexes a 14-bit active-low two-digit segment word onto one shared
// segment bus with per-digit anode enables and optional dead-time between digits.
// The input word is captured once per frame so a digit never tears mid-frame.
// Optional feature: define SEG7_LEADING_ZERO_BLANK_EN to blank a tens digit of zero.
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [13:0] displays,
  output logic [6:0]  seg,
  output logic [1:0]  an,
  output logic        frame_tick
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int TIMER_W    = $clog2(MAX_CYCLES + 1);
  localparam bit HAS_BLANK  = (BLANK_CYCLES > 0);
  // The timer is loaded with N-1 on entry: the entry cycle itself is the first
  // of the N cycles, and the exit edge is the one where the count reads zero.
  localparam int DIGIT_LOAD_INT = DIGIT_CYCLES - 1;
  localparam int BLANK_LOAD_INT = HAS_BLANK ? (BLANK_CYCLES - 1) : 0;
  localparam logic [TIMER_W-1:0] DIGIT_LOAD = TIMER_W'(DIGIT_LOAD_INT);
  localparam logic [TIMER_W-1:0] BLANK_LOAD = TIMER_W'(BLANK_LOAD_INT);

  scan_state_t        state_reg;
  scan_state_t        state_next;
  logic [13:0]        snap_reg;
  logic [6:0]         seg_reg;
  logic [6:0]         seg_next;
  logic [1:0]         an_reg;
  logic [1:0]         an_next;
  logic               tick_reg;
  logic               frame_start;
  logic               tens_blank;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_load_val;
  logic               timer_done;
  logic [6:0]         digit_seg [2];

  // Split the latched word into per-digit segment groups (0 = units, 1 = tens).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_digit
      assign digit_seg[gi] = snap_reg[gi*7 +: 7];
    end
  endgenerate

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  assign tens_blank = (digit_seg[1] == SEG_ZERO);
`else
  assign tens_blank = 1'b0;
`endif

  // Next phase: en low wins over everything, otherwise advance when the timer expires.
  always_comb begin
    state_next = state_reg;
    if (!en) begin
      state_next = S_OFF;
    end else begin
      case (state_reg)
        S_OFF:     state_next = S_UNITS;
        S_UNITS:   if (timer_done) state_next = HAS_BLANK ? S_BLANK_U : S_TENS;
        S_BLANK_U: if (timer_done) state_next = S_TENS;
        S_TENS:    if (timer_done) state_next = HAS_BLANK ? S_BLANK_T : S_UNITS;
        S_BLANK_T: if (timer_done) state_next = S_UNITS;
        default:   state_next = S_OFF;
      endcase
    end
  end

  // Every entry to the units phase starts a new frame and takes a new snapshot.
  assign frame_start = (state_next == S_UNITS) && (state_reg != S_UNITS);

  // Reload the phase timer whenever a new state is entered.
  always_comb begin
    timer_load     = (state_next != state_reg);
    timer_load_val = '0;
    case (state_next)
      S_UNITS, S_TENS:       timer_load_val = DIGIT_LOAD;
      S_BLANK_U, S_BLANK_T:  timer_load_val = BLANK_LOAD;
      default:               timer_load_val = '0;
    endcase
  end

  // Output values for the state being entered; a fresh frame shows the input directly.
  always_comb begin
    seg_next = SEG_OFF;
    an_next  = AN_OFF;
    case (state_next)
      S_UNITS: begin
        an_next  = 2'b10;
        seg_next = frame_start ? displays[6:0] : digit_seg[0];
      end
      S_TENS: begin
        an_next  = tens_blank ? AN_OFF : 2'b01;
        seg_next = tens_blank ? SEG_OFF : digit_seg[1];
      end
      default: begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
      end
    endcase
  end

  // Scan FSM with registered outputs and the per-frame snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_OFF;
      seg_reg   <= SEG_OFF;
      an_reg    <= AN_OFF;
      tick_reg  <= 1'b0;
      snap_reg  <= 14'h3FFF;
    end else begin
      state_reg <= state_next;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
      tick_reg  <= frame_start;
      if (frame_start) begin
        snap_reg <= displays;
      end
    end
  end

  scan_phase_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_load_val),
    .done     (timer_done)
  );

  assign seg        = seg_reg;
  assign an         = an_reg;
  assign frame_tick = tick_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus pushes per-cycle expected
// {an, seg, frame_tick} entries; a monitor pops and compares them after each edge.
module tb_seg7_scan_driver;

  localparam int D = 4;
  localparam int B = 2;

  localparam logic [6:0] U12 = 7'b0010010;
  localparam logic [6:0] T1  = 7'b1001111;
  localparam logic [6:0] U5  = 7'b0100100;
  localparam logic [6:0] T0  = 7'b0000001;
  localparam logic [6:0] U7  = 7'b0001111;

  typedef struct {
    int         cyc;
    bit         sel;
    logic [1:0] an;
    logic [6:0] seg;
    logic       tick;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        en0;
  logic [13:0] displays;
  logic [13:0] displays0;
  logic [6:0]  seg;
  logic [1:0]  an;
  logic        frame_tick;
  logic [6:0]  seg0;
  logic [1:0]  an0;
  logic        frame_tick0;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  seg7_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .displays   (displays),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  seg7_scan_driver #(.DIGIT_CYCLES(D), .BLANK_CYCLES(0)) dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en0),
    .displays   (displays0),
    .seg        (seg0),
    .an         (an0),
    .frame_tick (frame_tick0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int c, input logic [9:0] got, input logic [9:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got an=%b seg=%b tick=%b expected an=%b seg=%b tick=%b",
               name, c, got[9:8], got[7:1], got[0], want[9:8], want[7:1], want[0]);
    end else begin
      $display("ok   %s cyc=%0d an=%b seg=%b tick=%b", name, c, got[9:8], got[7:1], got[0]);
    end
  endtask

  task automatic push(input bit sel, input int c, input logic [1:0] a, input logic [6:0] s, input logic t);
    exp_t e;
    e.cyc = c; e.sel = sel; e.an = a; e.seg = s; e.tick = t;
    sb.push_back(e);
  endtask

  // Expected frame: units D cycles, blank bl, tens D cycles, blank bl; first len cycles only.
  task automatic push_frame(input bit sel, input int start, input int bl,
                            input logic [6:0] u, input logic [6:0] t, input int len);
    logic [1:0] tan;
    logic [6:0] tseg;
    tan  = 2'b01;
    tseg = t;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (t == 7'b0000001) begin
      tan  = 2'b11;
      tseg = 7'h7F;
    end
`endif
    for (int i = 0; i < 2*(D+bl) && i < len; i++) begin
      if (i < D)              push(sel, start+i, 2'b10, u, (i == 0));
      else if (i < D+bl)      push(sel, start+i, 2'b11, 7'h7F, 1'b0);
      else if (i < 2*D+bl)    push(sel, start+i, tan, tseg, 1'b0);
      else                    push(sel, start+i, 2'b11, 7'h7F, 1'b0);
    end
  endtask

  task automatic wait_neg(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  // Monitor: after each edge, compare every entry scheduled for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc < cyc) begin
          n_vec++;
          n_bad++;
          $display("FAIL stale_entry cyc=%0d scheduled for %0d", cyc, e.cyc);
        end else if (e.sel) begin
          check("scan_noblank", cyc, {an0, seg0, frame_tick0}, {e.an, e.seg, e.tick});
        end else begin
          check("scan", cyc, {an, seg, frame_tick}, {e.an, e.seg, e.tick});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst_n     = 1'b0;
    en        = 1'b0;
    en0       = 1'b0;
    displays  = {T1, U12};
    displays0 = {T1, T1};

    // Reset state
    wait_neg(3);
    check("reset_dut", cyc, {an, seg, frame_tick}, {2'b11, 7'h7F, 1'b0});
    check("reset_dut0", cyc, {an0, seg0, frame_tick0}, {2'b11, 7'h7F, 1'b0});

    // Release with en high: first frame tick on the next edge, "12" scanned
    rst_n = 1'b1;
    en    = 1'b1;
    s     = cyc + 1;
    push_frame(0, s,      B, U12, T1, 12);
    push_frame(0, s + 12, B, U12, T1, 12);

    // Change to "05" mid tens phase: current tens unchanged, next frame shows "05"
    wait_neg(s + 19);
    displays = {T0, U5};
    push_frame(0, s + 24, B, U5, T0, 12);
    push_frame(0, s + 36, B, U5, T0, 2);

    // Drop en for one cycle during units, then restart with a fresh "07" snapshot
    wait_neg(s + 37);
    en       = 1'b0;
    displays = {T0, U7};
    push(0, s + 38, 2'b11, 7'h7F, 1'b0);
    wait_neg(s + 38);
    en = 1'b1;
    push_frame(0, s + 39, B, U7, T0, 12);
    push_frame(0, s + 51, B, U7, T0, 8);

    // Asynchronous reset in the middle of the tens phase
    wait_neg(s + 58);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", cyc, {an, seg, frame_tick}, {2'b11, 7'h7F, 1'b0});

    // Release with en still high: tick one edge later
    wait_neg(s + 60);
    rst_n = 1'b1;
    push_frame(0, s + 61, B, U7, T0, 12);

    // No-blank instance: units/tens alternate every D cycles, tick every 2*D
    wait_neg(s + 73);
    en0 = 1'b1;
    push_frame(1, s + 74, 0, T1, T1, 8);
    push_frame(1, s + 82, 0, T1, T1, 8);
    push_frame(1, s + 90, 0, T1, T1, 1);

    wait_neg(s + 93);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending entries expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
